// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT result serializer.
package fft_pkg;

  localparam int FFT_OUT_W   = 11;
  localparam int FFT_NWORDS  = 6;
  localparam int FRAME_BYTES = 2 * FFT_NWORDS;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

  // Word order within a frame; also the shadow array index.
  localparam int IDX_A0_RE = 0;
  localparam int IDX_A1_RE = 1;
  localparam int IDX_A1_IM = 2;
  localparam int IDX_A2_RE = 3;
  localparam int IDX_A3_RE = 4;
  localparam int IDX_A3_IM = 5;

endpackage

// File: rtl/fft_result_serializer_if.sv
// FFT result capture port plus the 8-bit valid/ready output stream.
interface fft_result_serializer_if
  import fft_pkg::*;
#(
  parameter int W = FFT_OUT_W
);
  logic         load;
  logic [W-1:0] a0_re;
  logic [W-1:0] a1_re;
  logic [W-1:0] a1_im;
  logic [W-1:0] a2_re;
  logic [W-1:0] a3_re;
  logic [W-1:0] a3_im;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         frame_done;
  logic         overrun;

  modport master (
    output load, a0_re, a1_re, a1_im, a2_re, a3_re, a3_im, out_ready,
    input  out_data, out_valid, busy, frame_done, overrun
  );

  modport slave (
    input  load, a0_re, a1_re, a1_im, a2_re, a3_re, a3_im, out_ready,
    output out_data, out_valid, busy, frame_done, overrun
  );

endinterface

// File: rtl/fft_byte_mux.sv
// Selects the current output byte from the shadow words; high bytes are sign-extended.
module fft_byte_mux
  import fft_pkg::*;
#(
  parameter int W      = FFT_OUT_W,
  parameter int NWORDS = FFT_NWORDS
) (
  input  logic [NWORDS-1:0][W-1:0] words,
  input  logic [3:0]               byte_idx,
  input  logic                     en,
  output logic [7:0]               data
);

  localparam int IW = $clog2(NWORDS);

  logic [W-1:0] sel;
  logic [15:0]  ext;

  always_comb begin
    sel  = '0;
    ext  = '0;
    data = 8'h00;
    if (en) begin
      sel  = words[byte_idx[IW:1]];
      ext  = 16'($signed(sel));
      data = byte_idx[0] ? ext[15:8] : sel[7:0];
    end
  end

endmodule

// File: rtl/fft_result_serializer.sv
// Captures one FFT frame on load and drains it as 12 bytes over a valid/ready stream.
module fft_result_serializer
  import fft_pkg::*;
#(
  parameter int W      = FFT_OUT_W,
  parameter int NWORDS = FFT_NWORDS
) (
  input  logic                    clk,
  input  logic                    rst,
  fft_result_serializer_if.slave  io
);

  localparam logic [3:0] LAST_IDX = 4'(FRAME_BYTES - 1);

  ser_state_e               state_q, state_d;
  logic [3:0]               byte_idx_q, byte_idx_d;
  logic [NWORDS-1:0][W-1:0] shadow_q, shadow_d;
  logic                     frame_done_q, frame_done_d;
  logic                     overrun_q, overrun_d;

  logic fire;
  logic last_fire;
  logic [NWORDS-1:0][W-1:0] capture;

  always_comb begin
    capture            = '0;
    capture[IDX_A0_RE] = io.a0_re;
    capture[IDX_A1_RE] = io.a1_re;
    capture[IDX_A1_IM] = io.a1_im;
    capture[IDX_A2_RE] = io.a2_re;
    capture[IDX_A3_RE] = io.a3_re;
    capture[IDX_A3_IM] = io.a3_im;
  end

  assign fire      = (state_q == SEND) && io.out_ready;
  assign last_fire = fire && (byte_idx_q == LAST_IDX);

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    shadow_d     = shadow_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (io.load) begin
          shadow_d   = capture;
          byte_idx_d = '0;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (last_fire) begin
          frame_done_d = 1'b1;
          byte_idx_d   = '0;
          // A load on the final transfer chains the next frame without a bubble.
          if (io.load) shadow_d = capture;
          else         state_d  = IDLE;
        end else begin
          if (fire)    byte_idx_d = byte_idx_q + 4'd1;
          if (io.load) overrun_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      byte_idx_q   <= '0;
      shadow_q     <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      shadow_q     <= shadow_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  fft_byte_mux #(
    .W      (W),
    .NWORDS (NWORDS)
  ) u_byte_mux (
    .words    (shadow_q),
    .byte_idx (byte_idx_q),
    .en       (state_q == SEND),
    .data     (io.out_data)
  );

  assign io.out_valid  = (state_q == SEND);
  assign io.busy       = (state_q == SEND);
  assign io.frame_done = frame_done_q;
  assign io.overrun    = overrun_q;

endmodule

// File: tb/tb_fft_result_serializer.sv
// Directed bench for fft_result_serializer: single frame, backpressure, overrun, chaining, reset.
module tb_fft_result_serializer;
  import fft_pkg::*;

  logic clk;
  logic rst;
  int   pass_cnt;
  int   total_cnt;

  logic [10:0] fw [2][6];
  logic [7:0]  fb [2][12];

  fft_result_serializer_if #(.W(11)) io ();

  fft_result_serializer #(.W(11), .NWORDS(6)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input int f);
    io.a0_re = fw[f][0];
    io.a1_re = fw[f][1];
    io.a1_im = fw[f][2];
    io.a2_re = fw[f][3];
    io.a3_re = fw[f][4];
    io.a3_im = fw[f][5];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    io.load = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    io.load = 1'b1;
    io.out_ready = 1'b1;
    set_words(0);
    step();
    step();
    rst = 1'b0;
    io.load = 1'b0;
    total_cnt++; if (io.out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", io.out_valid); else pass_cnt++;
    total_cnt++; if (io.out_data !== 8'h00) $display("FAIL reset_data got %h want 00", io.out_data); else pass_cnt++;
    total_cnt++; if (io.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", io.busy); else pass_cnt++;
    total_cnt++; if (io.frame_done !== 1'b0) $display("FAIL reset_done got %b want 0", io.frame_done); else pass_cnt++;
    total_cnt++; if (io.overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", io.overrun); else pass_cnt++;
    step();
    step();
    total_cnt++; if (io.out_valid !== 1'b0) $display("FAIL idle_ready_valid got %b want 0", io.out_valid); else pass_cnt++;
  endtask

  task automatic test_single();
    io.out_ready = 1'b1;
    set_words(0);
    io.load = 1'b1;
    step();
    io.load = 1'b0;
    for (int k = 0; k < 12; k++) begin
      total_cnt++; if (io.out_valid !== 1'b1 || io.out_data !== fb[0][k]) $display("FAIL single_byte%0d got v=%b d=%h want v=1 d=%h", k, io.out_valid, io.out_data, fb[0][k]); else pass_cnt++;
      total_cnt++; if (io.frame_done !== 1'b0) $display("FAIL single_early_done%0d got %b want 0", k, io.frame_done); else pass_cnt++;
      step();
    end
    total_cnt++; if (io.frame_done !== 1'b1) $display("FAIL single_done got %b want 1", io.frame_done); else pass_cnt++;
    total_cnt++; if (io.busy !== 1'b0 || io.out_valid !== 1'b0) $display("FAIL single_idle got busy=%b v=%b want 0 0", io.busy, io.out_valid); else pass_cnt++;
    step();
    total_cnt++; if (io.frame_done !== 1'b0) $display("FAIL single_done_pulse got %b want 0", io.frame_done); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [7:0] got [12];
    logic [7:0] prev;
    logic       prev_hold;
    int         n;
    int         c;
    n = 0;
    c = 0;
    prev = 8'h00;
    prev_hold = 1'b0;
    set_words(0);
    io.load = 1'b1;
    io.out_ready = 1'b0;
    step();
    io.load = 1'b0;
    while (n < 12 && c < 60) begin
      io.out_ready = (c % 3 == 0);
      if (prev_hold) begin
        total_cnt++; if (io.out_data !== prev) $display("FAIL bp_hold c%0d got %h want %h", c, io.out_data, prev); else pass_cnt++;
      end
      if (io.out_valid && io.out_ready) begin
        got[n] = io.out_data;
        n++;
      end
      prev = io.out_data;
      prev_hold = io.out_valid && !io.out_ready;
      c++;
      step();
    end
    io.out_ready = 1'b1;
    total_cnt++; if (n !== 12) $display("FAIL bp_count got %0d want 12", n); else pass_cnt++;
    for (int k = 0; k < n; k++) begin
      total_cnt++; if (got[k] !== fb[0][k]) $display("FAIL bp_byte%0d got %h want %h", k, got[k], fb[0][k]); else pass_cnt++;
    end
    total_cnt++; if (io.frame_done !== 1'b1 || io.busy !== 1'b0) $display("FAIL bp_done got done=%b busy=%b want 1 0", io.frame_done, io.busy); else pass_cnt++;
    step();
  endtask

  task automatic test_overrun();
    io.out_ready = 1'b1;
    set_words(0);
    io.load = 1'b1;
    step();
    io.load = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k == 4) begin
        set_words(1);
        io.load = 1'b1;
      end else begin
        io.load = 1'b0;
      end
      total_cnt++; if (io.out_data !== fb[0][k]) $display("FAIL ovr_byte%0d got %h want %h", k, io.out_data, fb[0][k]); else pass_cnt++;
      step();
    end
    io.load = 1'b0;
    total_cnt++; if (io.overrun !== 1'b1) $display("FAIL ovr_set got %b want 1", io.overrun); else pass_cnt++;
    total_cnt++; if (io.busy !== 1'b0) $display("FAIL ovr_idle got busy=%b want 0", io.busy); else pass_cnt++;
    step();
    io.load = 1'b1;
    step();
    io.load = 1'b0;
    for (int k = 0; k < 12; k++) begin
      total_cnt++; if (io.out_data !== fb[1][k]) $display("FAIL ovr_next_byte%0d got %h want %h", k, io.out_data, fb[1][k]); else pass_cnt++;
      step();
    end
    total_cnt++; if (io.overrun !== 1'b1) $display("FAIL ovr_sticky got %b want 1", io.overrun); else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    io.out_ready = 1'b1;
    set_words(0);
    io.load = 1'b1;
    step();
    io.load = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k == 11) begin
        set_words(1);
        io.load = 1'b1;
      end
      total_cnt++; if (io.out_valid !== 1'b1 || io.out_data !== fb[0][k]) $display("FAIL b2b_a_byte%0d got v=%b d=%h want v=1 d=%h", k, io.out_valid, io.out_data, fb[0][k]); else pass_cnt++;
      step();
    end
    io.load = 1'b0;
    total_cnt++; if (io.frame_done !== 1'b1) $display("FAIL b2b_done got %b want 1", io.frame_done); else pass_cnt++;
    total_cnt++; if (io.overrun !== 1'b0) $display("FAIL b2b_overrun got %b want 0", io.overrun); else pass_cnt++;
    for (int k = 0; k < 12; k++) begin
      total_cnt++; if (io.out_valid !== 1'b1 || io.out_data !== fb[1][k]) $display("FAIL b2b_b_byte%0d got v=%b d=%h want v=1 d=%h", k, io.out_valid, io.out_data, fb[1][k]); else pass_cnt++;
      step();
    end
    total_cnt++; if (io.frame_done !== 1'b1 || io.busy !== 1'b0) $display("FAIL b2b_end got done=%b busy=%b want 1 0", io.frame_done, io.busy); else pass_cnt++;
    total_cnt++; if (io.overrun !== 1'b0) $display("FAIL b2b_overrun_end got %b want 0", io.overrun); else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid();
    io.out_ready = 1'b1;
    set_words(0);
    io.load = 1'b1;
    step();
    io.load = 1'b0;
    for (int k = 0; k < 6; k++) begin
      io.load = (k == 2);
      step();
    end
    io.load = 1'b0;
    total_cnt++; if (io.overrun !== 1'b1 || io.out_data !== fb[0][6]) $display("FAIL mid_pre got ovr=%b d=%h want 1 %h", io.overrun, io.out_data, fb[0][6]); else pass_cnt++;
    rst = 1'b1;
    step();
    rst = 1'b0;
    total_cnt++; if (io.out_valid !== 1'b0 || io.out_data !== 8'h00) $display("FAIL mid_rst_out got v=%b d=%h want 0 00", io.out_valid, io.out_data); else pass_cnt++;
    total_cnt++; if (io.busy !== 1'b0 || io.overrun !== 1'b0) $display("FAIL mid_rst_flags got busy=%b ovr=%b want 0 0", io.busy, io.overrun); else pass_cnt++;
    set_words(1);
    io.load = 1'b1;
    step();
    io.load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total_cnt++; if (io.out_valid !== 1'b1 || io.out_data !== fb[1][k]) $display("FAIL mid_restart_byte%0d got v=%b d=%h want v=1 d=%h", k, io.out_valid, io.out_data, fb[1][k]); else pass_cnt++;
      step();
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    fw[0][0] = 11'd1023;  fw[0][1] = 11'h7FF; fw[0][2] = 11'h400;
    fw[0][3] = 11'd0;     fw[0][4] = 11'd5;   fw[0][5] = 11'h7FB;
    fb[0][0] = 8'hFF; fb[0][1]  = 8'h03; fb[0][2]  = 8'hFF; fb[0][3]  = 8'hFF;
    fb[0][4] = 8'h00; fb[0][5]  = 8'hFC; fb[0][6]  = 8'h00; fb[0][7]  = 8'h00;
    fb[0][8] = 8'h05; fb[0][9]  = 8'h00; fb[0][10] = 8'hFB; fb[0][11] = 8'hFF;
    fw[1][0] = 11'h155;   fw[1][1] = 11'h700; fw[1][2] = 11'h100;
    fw[1][3] = 11'h0AA;   fw[1][4] = 11'h7FE; fw[1][5] = 11'h2F0;
    fb[1][0] = 8'h55; fb[1][1]  = 8'h01; fb[1][2]  = 8'h00; fb[1][3]  = 8'hFF;
    fb[1][4] = 8'h00; fb[1][5]  = 8'h01; fb[1][6]  = 8'hAA; fb[1][7]  = 8'h00;
    fb[1][8] = 8'hFE; fb[1][9]  = 8'hFF; fb[1][10] = 8'hF0; fb[1][11] = 8'h02;
    rst = 1'b1;
    io.load = 1'b0;
    io.out_ready = 1'b0;
    set_words(0);
    test_reset();
    test_single();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fft_result_serializer.md
Name: fft_result_serializer

Overview:
- Sits directly downstream of the 4-point FFT core.
- Captures one frame of six signed 11-bit FFT results (a0_re, a1_re, a1_im, a2_re, a3_re, a3_im) on a load strobe.
- Streams the frame out as 12 bytes over an 8-bit valid/ready interface sized for the chip's dedicated output pins.
- Frees the FFT core to accept the next input set while the previous frame drains.

Parameters:
- W, 11, width of each FFT result word; must satisfy 9 <= W <= 16.
- NWORDS, 6, words per frame; fixed by the FFT output set and not intended to be overridden.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high; clock clk
- load  input  1  one-cycle strobe: FFT outputs are valid this cycle, capture them
- a0_re  input  W  FFT bin 0 real (signed)
- a1_re  input  W  FFT bin 1 real
- a1_im  input  W  FFT bin 1 imaginary
- a2_re  input  W  FFT bin 2 real
- a3_re  input  W  FFT bin 3 real
- a3_im  input  W  FFT bin 3 imaginary
- out_data  output  8  current byte
- out_valid  output  1  out_data is valid
- out_ready  input  1  consumer accepts the byte this cycle
- busy  output  1  frame held/transmitting
- frame_done  output  1  one-cycle pulse when the last byte of a frame is accepted
- overrun  output  1  sticky: a load arrived while busy and was dropped

Behaviour:
- Reset values (sync, rst=1 dominates all inputs): state IDLE, out_valid=0, out_data=0x00, busy=0, frame_done=0, overrun=0, byte index=0, shadow regs=0.
- States:
  - IDLE: out_valid=0, out_data=0x00.
  - SEND: out_valid=1.
- IDLE -> SEND on load=1.
  - Capture all six words into shadow regs that cycle.
  - byte_idx=0.
  - out_valid=1 from the next cycle (1-cycle latency from load to first byte).
- Byte order: word order a0_re, a1_re, a1_im, a2_re, a3_re, a3_im.
  - For each word, low byte first: word[7:0].
  - Then high byte: word[W-1:8] sign-extended to 8 bits.
  - byte_idx 0..11: even = low byte, odd = high byte, word = byte_idx>>1.
- out_data is a function of registered shadow regs and byte_idx only. It holds stable while out_valid=1 and out_ready=0; no combinational path from out_ready to out_data or out_valid.
- Handshake in SEND: transfer when out_valid && out_ready.
  - byte_idx < 11: byte_idx increments.
  - byte_idx == 11: frame_done=1 for the next cycle, then return to IDLE with byte_idx=0.
- Back-to-back frames: load in the same cycle as the final transfer is accepted, not an overrun.
  - Shadow regs recapture, byte_idx=0, state stays SEND, out_valid stays 1 (no bubble).
  - frame_done still pulses.
- load while in SEND on any other cycle:
  - Ignored; shadow regs unchanged.
  - overrun set to 1 and held until rst.
- busy = 1 in SEND, 0 in IDLE.
- out_ready while out_valid=0 has no effect.
- rst mid-frame: the frame is discarded and all outputs return to reset values on the next edge.
- Integration: the FFT core registers its outputs. The top-level asserts load one cycle after it presents x0..x3 to the FFT.

Decomposition:
- Shared package fft_pkg:
  - FFT_OUT_W = 11
  - FFT_NWORDS = 6
  - FRAME_BYTES = 2*FFT_NWORDS
  - state enum {IDLE, SEND}
  - word-order index constants (IDX_A0_RE .. IDX_A3_IM)
- Sub-module: one natural one, fft_byte_mux (combinational). Maps shadow array + byte_idx to out_data, including the sign extension. Keeps the FSM file to control only.

Test Plan:
- Single frame, out_ready=1 always.
  - Stimulus: load with a0_re=1023, a1_re=-1, a1_im=-1024, a2_re=0, a3_re=5, a3_im=-5.
  - Required: bytes FF 03 FF FF 00 FC 00 00 05 00 FB FF on cycles 1..12 after load.
  - Required: frame_done pulses on the cycle after the last transfer, then busy=0.
- Backpressure.
  - Stimulus: same frame, out_ready toggling 1,0,0,1,...
  - Required: each byte held unchanged while out_ready=0; the same 12-byte sequence with no loss or duplication.
- Overrun.
  - Stimulus: load again at byte_idx=4 with different data.
  - Required: the original frame completes unchanged, overrun=1 and stays 1 through further frames until rst.
- Back-to-back.
  - Stimulus: second load coincident with the 12th transfer.
  - Required: out_valid never drops, the second frame's byte 0 follows immediately, overrun=0.
- Reset mid-frame.
  - Stimulus: rst at byte_idx=6.
  - Required: next cycle out_valid=0, out_data=0x00, busy=0, overrun=0; a fresh load restarts at byte 0.
